dmem_responder: RTL and testbench

Memory-side responder for the pipelined core's data port. Accepts load/store requests carrying address, write data, and a byte-lane write mask. Performs word-addressed array access with lane shifting, and returns read data plus a ready strobe after a configurable number of wait states. Sits between the core's `Addr_out`/`Data_out`/`mem_w`/`DMWType` outputs and its `Data_in`/`MIO_ready` inputs.

---
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
// ---------------------------------------------------------------------------
// Memory-side responder for the core's data port. A load/store request is
// accepted in IDLE and latched, the array is accessed on that same edge, and
// a one-cycle ready strobe follows WAIT_STATES+1 cycles later together with
// registered read data and an error flag.
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//   defined   : accesses with address bits above the array range report err
//               (store suppressed, load returns 0)
//   undefined : upper address bits are ignored, addresses wrap
//
// Ports
//   clk    in   clock
//   reset  in   asynchronous active-high reset
//   addr   in   [31:0] byte address, addr[1:0] selects the lane
//   wdata  in   [31:0] right-aligned store data
//   mem_w  in   store request (wins over mem_r)
//   mem_r  in   load request
//   wtype  in   [3:0] size mask: 0001 byte, 0011 halfword, 1111 word
//   rdata  out  [31:0] load data shifted to bit 0, upper bits zero
//   ready  out  one-cycle completion strobe
//   err    out  misaligned / illegal size / out of range, valid with ready
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_w,
    input  logic        mem_r,
    input  logic [3:0]  wtype,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int          ADDR_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        is_load_q;
    logic        req_err_q;
    logic [1:0]  lane_q;
    logic [3:0]  wtype_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------- request decode (combinational) ----------------
    logic              accept;
    logic              size_ok;
    logic              misalign;
    logic              oob;
    logic              req_err;
    logic              do_write;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        lane_en;
    logic [31:0]       wdata_sh;

    assign accept   = (state_q == IDLE) && (mem_w || mem_r);
    assign size_ok  = (wtype == 4'b0001) || (wtype == 4'b0011) || (wtype == 4'b1111);
    assign misalign = ((wtype == 4'b0011) && addr[0]) ||
                      ((wtype == 4'b1111) && (addr[1:0] != 2'b00));

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = ((addr >> (ADDR_W + 2)) != 32'd0);
`else
    // Upper bits deliberately ignored: the address wraps over the array.
    logic unused_hi;
    assign unused_hi = |(addr >> (ADDR_W + 2));
    assign oob       = 1'b0;
`endif

    assign req_err  = !size_ok || misalign || oob;
    assign idx      = addr[ADDR_W+1:2];
    assign lane_en  = wtype << addr[1:0];
    assign wdata_sh = wdata << {addr[1:0], 3'b000};
    // The array has no reset, so gate the write explicitly while reset is
    // asserted; the FSM is pinned in IDLE then and would otherwise accept.
    assign do_write = accept && mem_w && !req_err && !reset;

    // ---------------- array: write and read on the acceptance edge --------
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
        if (accept) word_q <= mem[idx];
    end

    // ---------------- load result formatting ----------------
    logic [31:0] shifted;
    logic [31:0] load_d;

    always_comb begin
        shifted = word_q >> {lane_q, 3'b000};
        load_d  = shifted;
        case (wtype_q)
            4'b0001: load_d = shifted & 32'h0000_00FF;
            4'b0011: load_d = shifted & 32'h0000_FFFF;
            default: load_d = shifted;
        endcase
        if (req_err_q) load_d = 32'd0;
    end

    // ---------------- control FSM with registered outputs ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            is_load_q <= 1'b0;
            req_err_q <= 1'b0;
            lane_q    <= 2'd0;
            wtype_q   <= 4'd0;
            rdata_q   <= 32'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (accept) begin
                        is_load_q <= !mem_w;       // store wins when both are high
                        req_err_q <= req_err;
                        lane_q    <= addr[1:0];
                        wtype_q   <= wtype;
                        cnt_q     <= WS_INIT;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        err_q   <= req_err_q;
                        if (is_load_q) rdata_q <= load_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps

module tb_dmem_responder;

    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata;
    logic        mem_w, mem_r;
    logic [3:0]  wtype;
    logic [31:0] rdata;
    logic        ready, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .mem_w (mem_w),
        .mem_r (mem_r),
        .wtype (wtype),
        .rdata (rdata),
        .ready (ready),
        .err   (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, push its expectation, wait (bounded) for ready, then
    // pop and compare latency, data and error; inputs are scrambled after
    // acceptance to confirm the request is latched.
    task automatic req(input string tag, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] t,
                       input logic [31:0] er, input logic ee);
        exp_t e;
        int   n;
        @(negedge clk);
        mem_w = w; mem_r = r; addr = a; wdata = d; wtype = t;
        e.rdata = er; e.err = ee;
        sb.push_back(e);
        @(posedge clk);
        #1;
        addr = $urandom; wdata = $urandom; wtype = 4'($urandom);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ready && n < 20);
        chk({tag, " latency"}, 32'(n), 32'(WS + 1));
        e = sb.pop_front();
        chk({tag, " rdata"}, rdata, e.rdata);
        chk({tag, " err"}, 32'(err), 32'(e.err));
        mem_w = 1'b0; mem_r = 1'b0;
        @(posedge clk); #1;
        chk({tag, " ready pulse"}, 32'(ready), 32'd0);
    endtask

    initial begin
        reset = 1'b1; mem_w = 1'b0; mem_r = 1'b0;
        addr = 32'd0; wdata = 32'd0; wtype = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset err",   32'(err),   32'd0);
        chk("reset rdata", rdata,      32'd0);
        @(negedge clk); reset = 1'b0;

        // word store / load
        req("st word",   1, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0,        0);
        req("ld word",   0, 1, 32'h10, 32'h0,        4'b1111, 32'hDEADBEEF, 0);
        // byte lane store
        req("st base",   1, 0, 32'h10, 32'h11223344, 4'b1111, 32'hDEADBEEF, 0);
        req("st byte3",  1, 0, 32'h13, 32'h000000AA, 4'b0001, 32'hDEADBEEF, 0);
        req("ld merged", 0, 1, 32'h10, 32'h0,        4'b1111, 32'hAA223344, 0);
        req("ld byte3",  0, 1, 32'h13, 32'h0,        4'b0001, 32'h000000AA, 0);
        // halfword misaligned store leaves memory unchanged
        req("st w20",    1, 0, 32'h20, 32'hCAFEF00D, 4'b1111, 32'h000000AA, 0);
        req("st hw mis", 1, 0, 32'h21, 32'h00001234, 4'b0011, 32'h000000AA, 1);
        req("ld w20",    0, 1, 32'h20, 32'h0,        4'b1111, 32'hCAFEF00D, 0);
        req("ld hw22",   0, 1, 32'h22, 32'h0,        4'b0011, 32'h0000CAFE, 0);
        req("ld byte21", 0, 1, 32'h21, 32'h0,        4'b0001, 32'h000000F0, 0);
        req("ld hw mis", 0, 1, 32'h21, 32'h0,        4'b0011, 32'h0,        1);
        req("ld illeg",  0, 1, 32'h20, 32'h0,        4'b0111, 32'h0,        1);
        req("st illeg",  1, 0, 32'h20, 32'hFFFFFFFF, 4'b0101, 32'h0,        1);
        req("st w mis",  1, 0, 32'h22, 32'h0,        4'b1111, 32'h0,        1);
        req("ld w20 b",  0, 1, 32'h20, 32'h0,        4'b1111, 32'hCAFEF00D, 0);
        // simultaneous: store wins, rdata untouched
        req("st+ld",     1, 1, 32'h30, 32'h5,        4'b1111, 32'hCAFEF00D, 0);
        req("ld w30",    0, 1, 32'h30, 32'h0,        4'b1111, 32'h00000005, 0);
        req("st hw32",   1, 0, 32'h32, 32'h0000BEEF, 4'b0011, 32'h00000005, 0);
        req("ld w30 b",  0, 1, 32'h30, 32'h0,        4'b1111, 32'hBEEF0005, 0);
        // bounds / wrap
        req("st w0",     1, 0, 32'h0,  32'h01020304, 4'b1111, 32'hBEEF0005, 0);
`ifdef DMEM_BOUNDS_CHECK_EN
        req("ld 1000",   0, 1, 32'h1000, 32'h0,      4'b1111, 32'h0,        1);
`else
        req("ld 1000",   0, 1, 32'h1000, 32'h0,      4'b1111, 32'h01020304, 0);
`endif
        // reset in the middle of a load
        req("ld pre",    0, 1, 32'h10, 32'h0,        4'b1111, 32'hAA223344, 0);
        @(negedge clk);
        mem_r = 1'b1; addr = 32'h30; wtype = 4'b1111;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst ready", 32'(ready), 32'd0);
        chk("midrst rdata", rdata,      32'd0);
        chk("midrst err",   32'(err),   32'd0);
        mem_r = 1'b0;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post rst idle", 32'(ready), 32'd0);
        end
        req("ld post",   0, 1, 32'h10, 32'h0,        4'b1111, 32'hAA223344, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
